mips16_single_cycle: RTL and testbench
======================================

Name: mips16_single_cycle

Overview:
- Single-cycle MIPS-style CPU: 32-bit instruction words, 16-bit datapath.
- Contains the PC, instruction memory, register file, ALU, data memory and control decoder.
- Also contains an iterative multiplier that stalls the PC.
- Every internal control signal is exported as a debug output for top-level benches.

Parameters:
- IMEM_DEPTH, 256: instruction words (32-bit). PC is a word index and wraps modulo IMEM_DEPTH.
- DMEM_DEPTH, 256: data words (16-bit), word-addressed by ALU result modulo DMEM_DEPTH.
- NUM_REGS, 32: 16-bit general registers; $0 reads 0 and ignores writes.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- instruction  out  32  current fetched word, imem[PC].
- op_code_out  out  6  instruction[31:26].
- func_out  out  6  instruction[5:0].
- alu_op_out  out  3  ALU operation select.
- out  out  16  register-file writeback data.
- reg_data_out_a  out  16  rs read data.
- reg_data_out_b  out  16  rt read data.
- mem_to_reg_out, mem_write_en_out, reg_write_en_out, alu_reset_out, imm_sl_out, br_sl_out, breq_sl_out, reg_dest_out, jump_sl_out, jump_reg_sl_out, instr_stall_sl_out, ready_out, hi_lo_sl_out  out  1 each  decoded controls (see Behaviour).

Behaviour:
- Memory organisation:
  - Instruction memory is an internal array named instruction_registers.register.
  - Register file is an internal array named data_registers.register.
  - Both sit under an internal datapath instance named d1.
  - Instruction memory is preloaded by hierarchical $readmemb and is not reset.
- Reset:
  - PC, hi, lo, multiplier state and all registers clear to 0.
  - Data memory is not cleared.
  - All outputs are then the combinational decode of imem[0].
- Decode and execute, one instruction per cycle (combinational):
  - R-type op 0x00 by funct: add 20, sub 22, and 24, or 25, xor 26, nor 27, slt 2A, jr 08, mult 18, mfhi 10, mflo 12.
  - I-type: addi 08, slti 0A, andi 0C, ori 0D, lw 23, sw 2B, beq 04, bne 05.
  - J-type: j 02.
  - Undefined opcodes and functs execute as nop.
- alu_op encoding: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed), 101 nor, 110 xor, 111 pass-B.
- Immediate is instruction[15:0] used directly. Arithmetic wraps mod 2^16.
- Control outputs:
  - imm_sl: ALU B operand is the immediate.
  - reg_dest: 1 = destination rd[4:0], 0 = destination rt.
  - mem_to_reg: writeback data comes from dmem.
  - reg_write_en: asserted for ALU ops, lw, mfhi and mflo; for mult only on the completing cycle, which writes nothing to the register file.
- Branches:
  - br_sl = 1 for beq/bne; breq_sl = 1 for beq, 0 for bne.
  - Condition uses rs==rt (ALU subtract result zero).
  - Taken target = PC+1+imm.
- Jumps:
  - jump_sl: PC = instruction[25:0] modulo IMEM_DEPTH.
  - jump_reg_sl: PC = rs.
- Next-PC priority: stall > jump_reg > jump > taken branch > PC+1.
- mult (16x16 unsigned, shift-add, 1 bit per cycle):
  - First cycle: alu_reset_out=1 clears the accumulator and loads the operands. instr_stall_sl=1 and ready=0 for 16 cycles in total.
  - On the 16th cycle: ready=1, {hi,lo} is written, and the PC advances.
  - ready=1 whenever the multiplier is idle.
- hi_lo_sl: 1 selects hi (mfhi), 0 selects lo (mflo).
- A register write and a read of the same register in one cycle reads the old value.
- Reset asserted mid-mult aborts the multiply; hi and lo are 0.

Decomposition:
- Shared package mips16_pkg holds:
  - opcode constants
  - funct constants
  - the alu_op encoding
  - DATA_W=16, INSTR_W=32
- One natural sub-module: mips16_mult_unit, the iterative multiplier with start/reset, busy/ready and a 32-bit product.

Test Plan:
- OR/ORI:
  - Program: addi $1,$0,0x00F0; addi $2,$0,0x0F0F; or $3,$1,$2; ori $4,$1,2.
  - Required: after 4 cycles reg3=0x0FFF and reg4=0x00F2. During the or cycle op_code=0, func=0x25, alu_op=011, reg_dest=1, imm_sl=0.
- Memory:
  - Program: sw $1,5($0) then lw $5,5($0).
  - Required: reg5=0x00F0. mem_write_en=1 only on the sw cycle; mem_to_reg=1 only on the lw cycle.
- Branch:
  - beq $1,$1,+2 → PC skips two instructions; br_sl=1, breq_sl=1.
  - bne $1,$1,+2 → falls through.
- Jumps:
  - j 10 → PC=10.
  - jr $6 with reg6=20 → PC=20, jump_reg_sl=1.
- Multiply:
  - $1=0x1234, $2=0x0010, mult then mflo $7, mfhi $8.
  - Required: stall for 16 cycles, then reg7=0x2340 and reg8=0x0001.
- Reset:
  - Assert reset mid-mult → PC=0, registers 0, ready=1 after release.
  - Writing $0 leaves it reading 0.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared opcode/funct constants, ALU operation encoding and the ALU evaluation helper
// for the 16-bit single-cycle MIPS-style core.
package mips16_pkg;

    localparam int DATA_W  = 16;
    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_SLT   = 3'b100,
        ALU_NOR   = 3'b101,
        ALU_XOR   = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;

    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  funct_to_alu = ALU_SUB;
            FN_AND:  funct_to_alu = ALU_AND;
            FN_OR:   funct_to_alu = ALU_OR;
            FN_XOR:  funct_to_alu = ALU_XOR;
            FN_NOR:  funct_to_alu = ALU_NOR;
            FN_SLT:  funct_to_alu = ALU_SLT;
            default: funct_to_alu = ALU_ADD;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] alu_eval(input alu_op_e op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        case (op)
            ALU_ADD:   alu_eval = a + b;
            ALU_SUB:   alu_eval = a - b;
            ALU_AND:   alu_eval = a & b;
            ALU_OR:    alu_eval = a | b;
            ALU_SLT:   alu_eval = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            ALU_NOR:   alu_eval = ~(a | b);
            ALU_XOR:   alu_eval = a ^ b;
            ALU_PASSB: alu_eval = b;
            default:   alu_eval = a + b;
        endcase
    endfunction

endpackage

// File: rtl/mips16_datapath.sv
// Datapath: PC, instruction memory, register file, ALU, data memory, hi/lo and the multiplier.
// Decoded controls arrive from the top; everything here is one instruction per clock.
module mips16_datapath
    import mips16_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int NUM_REGS   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  alu_op_e            alu_op_i,
    input  logic               imm_sl_i,
    input  logic               reg_dest_i,
    input  logic               mem_to_reg_i,
    input  logic               mem_write_en_i,
    input  logic               reg_write_en_i,
    input  logic               br_sl_i,
    input  logic               breq_sl_i,
    input  logic               jump_sl_i,
    input  logic               jump_reg_sl_i,
    input  logic               hi_lo_sl_i,
    input  logic               hilo_rd_i,
    input  logic               mult_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [DATA_W-1:0]  rs_data_o,
    output logic [DATA_W-1:0]  rt_data_o,
    output logic [DATA_W-1:0]  wb_data_o,
    output logic               alu_reset_o,
    output logic               stall_o,
    output logic               ready_o,
    output logic               mult_done_o
);

    localparam int PC_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic [DATA_W-1:0]   dmem_q [DMEM_DEPTH];
    logic [DATA_W-1:0]   b_op_s, alu_res_s, dmem_rd_s;
    logic [4:0]          dest_s;
    logic                rf_we_s, taken_s;
    logic [2*DATA_W-1:0] product_s;

    mips16_imem #(.DEPTH(IMEM_DEPTH), .AW(PC_W)) instruction_registers (
        .clk_i(clk_i), .we_i(1'b0), .waddr_i({PC_W{1'b0}}), .wdata_i(32'd0),
        .raddr_i(pc_q), .rdata_o(instr_o)
    );

    assign dest_s  = reg_dest_i ? instr_o[15:11] : instr_o[20:16];
    assign rf_we_s = reg_write_en_i & ~mult_i;

    mips16_regfile #(.NUM_REGS(NUM_REGS)) data_registers (
        .clk_i(clk_i), .rst_i(rst_i), .we_i(rf_we_s), .waddr_i(dest_s), .wdata_i(wb_data_o),
        .raddr_a_i(instr_o[25:21]), .raddr_b_i(instr_o[20:16]),
        .rdata_a_o(rs_data_o), .rdata_b_o(rt_data_o)
    );

    mips16_mult_unit u_mult (
        .clk_i(clk_i), .rst_i(rst_i), .mult_i(mult_i), .a_i(rs_data_o), .b_i(rt_data_o),
        .start_o(alu_reset_o), .stall_o(stall_o), .ready_o(ready_o), .done_o(mult_done_o),
        .product_o(product_s)
    );

    assign b_op_s    = imm_sl_i ? instr_o[15:0] : rt_data_o;
    assign alu_res_s = alu_eval(alu_op_i, rs_data_o, b_op_s);
    assign dmem_rd_s = dmem_q[alu_res_s[DA_W-1:0]];
    assign taken_s   = br_sl_i & ((alu_res_s == 16'd0) == breq_sl_i);

    // Writeback source: data memory, hi/lo, or the ALU result.
    always_comb begin
        if (mem_to_reg_i) begin
            wb_data_o = dmem_rd_s;
        end else if (hilo_rd_i) begin
            wb_data_o = hi_lo_sl_i ? hi_q : lo_q;
        end else begin
            wb_data_o = alu_res_s;
        end
    end

    // Next PC: stall > jump_reg > jump > taken branch > sequential.
    always_comb begin
        pc_d = pc_q + PC_ONE;
        if (stall_o) begin
            pc_d = pc_q;
        end else if (jump_reg_sl_i) begin
            pc_d = rs_data_o[PC_W-1:0];
        end else if (jump_sl_i) begin
            pc_d = instr_o[PC_W-1:0];
        end else if (taken_s) begin
            pc_d = pc_q + PC_ONE + instr_o[PC_W-1:0];
        end else begin
            pc_d = pc_q + PC_ONE;
        end
    end

    // PC and hi/lo; hi/lo load only on the completing multiply cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= {PC_W{1'b0}};
            hi_q <= 16'd0;
            lo_q <= 16'd0;
        end else begin
            pc_q <= pc_d;
            if (mult_done_o) begin
                {hi_q, lo_q} <= product_s;
            end
        end
    end

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_write_en_i) begin
            dmem_q[alu_res_s[DA_W-1:0]] <= rt_data_o;
        end
    end

endmodule

// File: rtl/mips16_mem.sv
// Storage arrays of the core: the instruction word store (preloaded from outside, never reset)
// and the general register file ($0 hard-wired to zero, reads see the pre-write value).
module mips16_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] register [DEPTH];

    assign rdata_o = register[raddr_i];

    // Optional write port, kept so the array has an in-design driver.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            register[waddr_i] <= wdata_i;
        end
    end

endmodule

module mips16_regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [15:0] rdata_a_o,
    output logic [15:0] rdata_b_o
);

    logic [15:0] register [NUM_REGS];

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 16'd0 : register[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 16'd0 : register[raddr_b_i];

    // Register array with writes to $0 discarded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                register[i] <= 16'd0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            register[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/mips16_mult_unit.sv
// Iterative 16x16 unsigned shift-add multiplier, one multiplier bit per cycle.
// Bit 0 is folded into the load cycle and bit 15 into the completing cycle, so a mult occupies 16 cycles.
module mips16_mult_unit
    import mips16_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mult_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  start_o,
    output logic                  stall_o,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    logic                busy_q, busy_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] term_s;

    assign start_o   = mult_i & ~busy_q;
    assign done_o    = busy_q & (cnt_q == 4'd15);
    assign term_s    = mplier_q[0] ? mcand_q : 32'd0;
    assign product_o = acc_q + term_s;
    assign stall_o   = start_o | (busy_q & ~done_o);
    assign ready_o   = ~start_o & (~busy_q | done_o);

    // Next-state: load on start, accumulate one bit per busy cycle, release on the last bit.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start_o) begin
            busy_d   = 1'b1;
            cnt_d    = 4'd1;
            acc_d    = b_i[0] ? {16'd0, a_i} : 32'd0;
            mcand_d  = {15'd0, a_i, 1'b0};
            mplier_d = {1'b0, b_i[DATA_W-1:1]};
        end else if (done_o) begin
            busy_d = 1'b0;
            cnt_d  = 4'd0;
        end else if (busy_q) begin
            acc_d    = acc_q + term_s;
            mcand_d  = {mcand_q[2*DATA_W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
            cnt_d    = cnt_q + 4'd1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state register; reset aborts any multiply in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= 4'd0;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 16'd0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/mips16_single_cycle.sv
// Top of the single-cycle 16-bit MIPS-style CPU: instruction decoder plus the datapath d1.
// Every decoded control is exported so benches can observe the decode directly.
module mips16_single_cycle
    import mips16_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int NUM_REGS   = 32
) (
    input  logic                clock,
    input  logic                reset,
    output logic [INSTR_W-1:0]  instruction,
    output logic [5:0]          op_code_out,
    output logic [5:0]          func_out,
    output logic [2:0]          alu_op_out,
    output logic [DATA_W-1:0]   out,
    output logic [DATA_W-1:0]   reg_data_out_a,
    output logic [DATA_W-1:0]   reg_data_out_b,
    output logic                mem_to_reg_out,
    output logic                mem_write_en_out,
    output logic                reg_write_en_out,
    output logic                alu_reset_out,
    output logic                imm_sl_out,
    output logic                br_sl_out,
    output logic                breq_sl_out,
    output logic                reg_dest_out,
    output logic                jump_sl_out,
    output logic                jump_reg_sl_out,
    output logic                instr_stall_sl_out,
    output logic                ready_out,
    output logic                hi_lo_sl_out
);

    alu_op_e alu_op_s;
    logic    hilo_rd_s, mult_s, mult_done_s;

    assign op_code_out = instruction[31:26];
    assign func_out    = instruction[5:0];
    assign alu_op_out  = alu_op_s;

    // Instruction decode; anything unrecognised falls through as a nop.
    always_comb begin
        alu_op_s         = ALU_ADD;
        imm_sl_out       = 1'b0;
        reg_dest_out     = 1'b0;
        mem_to_reg_out   = 1'b0;
        mem_write_en_out = 1'b0;
        reg_write_en_out = 1'b0;
        br_sl_out        = 1'b0;
        breq_sl_out      = 1'b0;
        jump_sl_out      = 1'b0;
        jump_reg_sl_out  = 1'b0;
        hi_lo_sl_out     = 1'b0;
        hilo_rd_s        = 1'b0;
        mult_s           = 1'b0;
        case (op_code_out)
            OP_RTYPE: begin
                case (func_out)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: begin
                        alu_op_s         = funct_to_alu(func_out);
                        reg_write_en_out = 1'b1;
                        reg_dest_out     = 1'b1;
                    end
                    FN_JR: jump_reg_sl_out = 1'b1;
                    FN_MULT: begin
                        mult_s           = 1'b1;
                        reg_write_en_out = mult_done_s;
                    end
                    FN_MFHI, FN_MFLO: begin
                        hilo_rd_s        = 1'b1;
                        hi_lo_sl_out     = (func_out == FN_MFHI);
                        reg_write_en_out = 1'b1;
                        reg_dest_out     = 1'b1;
                    end
                    default: alu_op_s = ALU_ADD;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                imm_sl_out       = 1'b1;
                reg_write_en_out = 1'b1;
                alu_op_s = (op_code_out == OP_SLTI) ? ALU_SLT :
                           (op_code_out == OP_ANDI) ? ALU_AND :
                           (op_code_out == OP_ORI)  ? ALU_OR  : ALU_ADD;
            end
            OP_LW: begin
                imm_sl_out       = 1'b1;
                mem_to_reg_out   = 1'b1;
                reg_write_en_out = 1'b1;
            end
            OP_SW: begin
                imm_sl_out       = 1'b1;
                mem_write_en_out = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_op_s    = ALU_SUB;
                br_sl_out   = 1'b1;
                breq_sl_out = (op_code_out == OP_BEQ);
            end
            OP_J:    jump_sl_out = 1'b1;
            default: alu_op_s = ALU_ADD;
        endcase
    end

    mips16_datapath #(
        .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .NUM_REGS(NUM_REGS)
    ) d1 (
        .clk_i(clock), .rst_i(reset), .alu_op_i(alu_op_s), .imm_sl_i(imm_sl_out),
        .reg_dest_i(reg_dest_out), .mem_to_reg_i(mem_to_reg_out),
        .mem_write_en_i(mem_write_en_out), .reg_write_en_i(reg_write_en_out),
        .br_sl_i(br_sl_out), .breq_sl_i(breq_sl_out), .jump_sl_i(jump_sl_out),
        .jump_reg_sl_i(jump_reg_sl_out), .hi_lo_sl_i(hi_lo_sl_out), .hilo_rd_i(hilo_rd_s),
        .mult_i(mult_s), .instr_o(instruction), .rs_data_o(reg_data_out_a),
        .rt_data_o(reg_data_out_b), .wb_data_o(out), .alu_reset_o(alu_reset_out),
        .stall_o(instr_stall_sl_out), .ready_o(ready_out), .mult_done_o(mult_done_s)
    );

endmodule

// File: tb/tb_mips16_single_cycle.sv
// Directed program bench for mips16_single_cycle: preloads a program, then checks decode,
// writeback, branch/jump targets, the 16-cycle multiply and reset behaviour step by step.
module tb_mips16_single_cycle;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [5:0]  op_code_out, func_out;
    logic [2:0]  alu_op_out;
    logic [15:0] out_s, reg_data_out_a, reg_data_out_b;
    logic        mem_to_reg_out, mem_write_en_out, reg_write_en_out, alu_reset_out;
    logic        imm_sl_out, br_sl_out, breq_sl_out, reg_dest_out, jump_sl_out;
    logic        jump_reg_sl_out, instr_stall_sl_out, ready_out, hi_lo_sl_out;

    int n_assert = 0;
    int n_fail   = 0;

    mips16_single_cycle dut (
        .clock(clock), .reset(reset), .instruction(instruction), .op_code_out(op_code_out),
        .func_out(func_out), .alu_op_out(alu_op_out), .out(out_s),
        .reg_data_out_a(reg_data_out_a), .reg_data_out_b(reg_data_out_b),
        .mem_to_reg_out(mem_to_reg_out), .mem_write_en_out(mem_write_en_out),
        .reg_write_en_out(reg_write_en_out), .alu_reset_out(alu_reset_out),
        .imm_sl_out(imm_sl_out), .br_sl_out(br_sl_out), .breq_sl_out(breq_sl_out),
        .reg_dest_out(reg_dest_out), .jump_sl_out(jump_sl_out),
        .jump_reg_sl_out(jump_reg_sl_out), .instr_stall_sl_out(instr_stall_sl_out),
        .ready_out(ready_out), .hi_lo_sl_out(hi_lo_sl_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one instruction and sample mid-cycle
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) dut.d1.instruction_registers.register[i] <= 32'd0;
        dut.d1.instruction_registers.register[0]  <= enc_i(6'h08, 5'd0, 5'd1, 16'h00F0);
        dut.d1.instruction_registers.register[1]  <= enc_i(6'h08, 5'd0, 5'd2, 16'h0F0F);
        dut.d1.instruction_registers.register[2]  <= enc_r(5'd1, 5'd2, 5'd3, 6'h25);
        dut.d1.instruction_registers.register[3]  <= enc_i(6'h0D, 5'd1, 5'd4, 16'h0002);
        dut.d1.instruction_registers.register[4]  <= enc_i(6'h2B, 5'd0, 5'd1, 16'h0005);
        dut.d1.instruction_registers.register[5]  <= enc_i(6'h23, 5'd0, 5'd5, 16'h0005);
        dut.d1.instruction_registers.register[6]  <= enc_i(6'h04, 5'd1, 5'd1, 16'h0002);
        dut.d1.instruction_registers.register[7]  <= enc_i(6'h08, 5'd0, 5'd9, 16'h0001);
        dut.d1.instruction_registers.register[8]  <= enc_i(6'h08, 5'd0, 5'd9, 16'h0002);
        dut.d1.instruction_registers.register[9]  <= enc_i(6'h05, 5'd1, 5'd1, 16'h0002);
        dut.d1.instruction_registers.register[10] <= enc_i(6'h08, 5'd0, 5'd6, 16'd20);
        dut.d1.instruction_registers.register[11] <= {6'h02, 26'd14};
        dut.d1.instruction_registers.register[12] <= enc_i(6'h08, 5'd0, 5'd10, 16'h0001);
        dut.d1.instruction_registers.register[13] <= enc_i(6'h08, 5'd0, 5'd10, 16'h0001);
        dut.d1.instruction_registers.register[14] <= enc_r(5'd6, 5'd0, 5'd0, 6'h08);
        dut.d1.instruction_registers.register[20] <= enc_i(6'h08, 5'd0, 5'd1, 16'h1234);
        dut.d1.instruction_registers.register[21] <= enc_i(6'h08, 5'd0, 5'd2, 16'h0010);
        dut.d1.instruction_registers.register[22] <= enc_r(5'd1, 5'd2, 5'd0, 6'h18);
        dut.d1.instruction_registers.register[23] <= enc_r(5'd0, 5'd0, 5'd7, 6'h12);
        dut.d1.instruction_registers.register[24] <= enc_r(5'd0, 5'd0, 5'd8, 6'h10);
        dut.d1.instruction_registers.register[25] <= enc_i(6'h08, 5'd0, 5'd0, 16'h0005);
        dut.d1.instruction_registers.register[26] <= enc_r(5'd0, 5'd0, 5'd11, 6'h20);
        dut.d1.instruction_registers.register[27] <= enc_r(5'd1, 5'd2, 5'd0, 6'h18);

        @(negedge clock);
        chk("rst_pc", dut.d1.pc_q, 32'd0);
        chk("rst_ready", ready_out, 32'd1);
        chk("rst_instr", instruction, 32'h200100F0);
        chk("rst_opcode", op_code_out, 32'h08);
        chk("rst_reg1", dut.d1.data_registers.register[1], 32'h0);
        reset = 1'b0;
        #1;
        chk("addi1_out", out_s, 32'h00F0);
        chk("addi1_imm_sl", imm_sl_out, 32'd1);
        chk("addi1_reg_dest", reg_dest_out, 32'd0);
        chk("addi1_we", reg_write_en_out, 32'd1);
        step();
        chk("addi2_out", out_s, 32'h0F0F);
        step();
        chk("or_opcode", op_code_out, 32'h00);
        chk("or_func", func_out, 32'h25);
        chk("or_alu_op", alu_op_out, 32'b011);
        chk("or_reg_dest", reg_dest_out, 32'd1);
        chk("or_imm_sl", imm_sl_out, 32'd0);
        chk("or_out", out_s, 32'h0FFF);
        step();
        chk("reg3", dut.d1.data_registers.register[3], 32'h0FFF);
        chk("ori_out", out_s, 32'h00F2);
        step();
        chk("reg4", dut.d1.data_registers.register[4], 32'h00F2);
        chk("sw_mem_we", mem_write_en_out, 32'd1);
        chk("sw_mem_to_reg", mem_to_reg_out, 32'd0);
        chk("sw_reg_we", reg_write_en_out, 32'd0);
        step();
        chk("lw_mem_we", mem_write_en_out, 32'd0);
        chk("lw_mem_to_reg", mem_to_reg_out, 32'd1);
        chk("lw_out", out_s, 32'h00F0);
        step();
        chk("reg5", dut.d1.data_registers.register[5], 32'h00F0);
        chk("beq_br_sl", br_sl_out, 32'd1);
        chk("beq_breq_sl", breq_sl_out, 32'd1);
        chk("beq_mem_to_reg", mem_to_reg_out, 32'd0);
        step();
        chk("beq_target_pc", dut.d1.pc_q, 32'd9);
        chk("bne_br_sl", br_sl_out, 32'd1);
        chk("bne_breq_sl", breq_sl_out, 32'd0);
        step();
        chk("bne_fallthru_pc", dut.d1.pc_q, 32'd10);
        step();
        chk("j_jump_sl", jump_sl_out, 32'd1);
        step();
        chk("j_target_pc", dut.d1.pc_q, 32'd14);
        chk("reg9_untouched", dut.d1.data_registers.register[9], 32'h0);
        chk("jr_jump_reg_sl", jump_reg_sl_out, 32'd1);
        chk("jr_rs_data", reg_data_out_a, 32'd20);
        step();
        chk("jr_target_pc", dut.d1.pc_q, 32'd20);
        step();
        step();
        chk("mult_start_pc", dut.d1.pc_q, 32'd22);
        chk("mult_alu_reset", alu_reset_out, 32'd1);
        chk("mult_start_stall", instr_stall_sl_out, 32'd1);
        chk("mult_start_ready", ready_out, 32'd0);
        chk("mult_start_we", reg_write_en_out, 32'd0);
        for (int c = 2; c <= 15; c++) begin
            step();
            chk($sformatf("mult_stall_c%0d", c), {alu_reset_out, instr_stall_sl_out, ready_out},
                32'b010);
        end
        step();
        chk("mult_last_pc", dut.d1.pc_q, 32'd22);
        chk("mult_last_ready", ready_out, 32'd1);
        chk("mult_last_stall", instr_stall_sl_out, 32'd0);
        chk("mult_last_we", reg_write_en_out, 32'd1);
        step();
        chk("mflo_pc", dut.d1.pc_q, 32'd23);
        chk("mflo_hi_lo_sl", hi_lo_sl_out, 32'd0);
        chk("mflo_out", out_s, 32'h2340);
        step();
        chk("reg7", dut.d1.data_registers.register[7], 32'h2340);
        chk("mfhi_hi_lo_sl", hi_lo_sl_out, 32'd1);
        chk("mfhi_out", out_s, 32'h0001);
        step();
        chk("reg8", dut.d1.data_registers.register[8], 32'h0001);
        step();
        chk("reg0_zero", dut.d1.data_registers.register[0], 32'h0);
        chk("reg0_read", reg_data_out_a, 32'h0);
        chk("add_zero_out", out_s, 32'h0);
        step();
        chk("mult2_stall", instr_stall_sl_out, 32'd1);
        step();
        step();
        step();
        chk("mult2_mid_stall", instr_stall_sl_out, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_pc", dut.d1.pc_q, 32'd0);
        chk("rst_mid_reg1", dut.d1.data_registers.register[1], 32'h0);
        chk("rst_mid_hi", dut.d1.hi_q, 32'h0);
        chk("rst_mid_lo", dut.d1.lo_q, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", ready_out, 32'd1);
        chk("post_rst_stall", instr_stall_sl_out, 32'd0);
        chk("post_rst_pc", dut.d1.pc_q, 32'd0);
        chk("post_rst_reg7", dut.d1.data_registers.register[7], 32'h0);
        chk("post_rst_out", out_s, 32'h00F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
